// File: rtl/player_input_regs.sv
// Player input peripheral: synchronises and debounces both players' door
// switches, latches the first one-hot door choice per player, latches
// time_up rising edges, and exposes STATUS/RAW on the core's read bus with
// clear-on-read of STATUS.
`timescale 1ns/1ps

module player_input_regs #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned CNT_W           = 18,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_j1,
    input  logic [3:0]  sw_j2,
    input  logic        time_up,
    input  logic [31:0] addr,
    input  logic        re,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        event_pending
);

    localparam int unsigned SW_W = 4;
    localparam int unsigned N_PL = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RAW_ADDR = BASE_ADDR + 32'd4;

    // Index 0 is player 1, index 1 is player 2.
    logic [N_PL-1:0][SW_W-1:0]  sw_in;
    logic [N_PL-1:0][SW_W-1:0]  sync1_q, sync1_d;
    logic [N_PL-1:0][SW_W-1:0]  sync2_q, sync2_d;
    logic [N_PL-1:0][SW_W-1:0]  deb_q, deb_d;
    logic [N_PL-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_PL-1:0]            upd_q, upd_d;
    logic [N_PL-1:0]            valid_q, valid_d;
    logic [N_PL-1:0][1:0]       choice_q, choice_d;
    logic                       tu_prev_q, tu_prev_d;
    logic                       tu_seen_q, tu_seen_d;
    logic                       event_pending_q, event_pending_d;
    logic                       clr_c;
    logic [N_PL-1:0]            latch_c;

    assign sw_in = {sw_j2, sw_j1};

    function automatic logic is_onehot(input logic [SW_W-1:0] v);
        return (v != '0) && ((v & (v - SW_W'(1))) == '0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [SW_W-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int b = 0; b < int'(SW_W); b++) begin
            if (v[b]) idx = 2'(b);
        end
        return idx;
    endfunction

    // Next-state: sync pipeline, debounce, choice latch, time_up edge, clear-on-read.
    always_comb begin
        sync1_d         = sw_in;
        sync2_d         = sync1_q;
        deb_d           = deb_q;
        cnt_d           = cnt_q;
        upd_d           = '0;
        valid_d         = valid_q;
        choice_d        = choice_q;
        latch_c         = '0;
        clr_c           = re && (addr == BASE_ADDR);

        for (int p = 0; p < int'(N_PL); p++) begin
            // Choice uses the debounced vector one edge after it was updated;
            // a new latch beats a simultaneous clear.
            latch_c[p] = upd_q[p] && is_onehot(deb_q[p]) && !valid_q[p];
            if (latch_c[p]) begin
                valid_d[p]  = 1'b1;
                choice_d[p] = onehot_idx(deb_q[p]);
            end else if (clr_c) begin
                valid_d[p]  = 1'b0;
                choice_d[p] = 2'd0;
            end

            // Count consecutive cycles the synced vector disagrees with d.
            if (sync2_q[p] == deb_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] == CNT_LAST) begin
                deb_d[p] = sync2_q[p];
                cnt_d[p] = '0;
                upd_d[p] = 1'b1;
            end else begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end

        tu_prev_d       = time_up;
        tu_seen_d       = (time_up && !tu_prev_q) || (tu_seen_q && !clr_c);
        event_pending_d = (|valid_d) || tu_seen_d;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            deb_q           <= '0;
            cnt_q           <= '0;
            upd_q           <= '0;
            valid_q         <= '0;
            choice_q        <= '0;
            tu_prev_q       <= 1'b0;
            tu_seen_q       <= 1'b0;
            event_pending_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            deb_q           <= deb_d;
            cnt_q           <= cnt_d;
            upd_q           <= upd_d;
            valid_q         <= valid_d;
            choice_q        <= choice_d;
            tu_prev_q       <= tu_prev_d;
            tu_seen_q       <= tu_seen_d;
            event_pending_q <= event_pending_d;
        end
    end

    // Zero-latency read decode.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (addr == BASE_ADDR) begin
            rd_hit       = 1'b1;
            rd_data[0]   = valid_q[0];
            rd_data[1]   = valid_q[1];
            rd_data[3:2] = choice_q[0];
            rd_data[5:4] = choice_q[1];
            rd_data[8]   = tu_seen_q;
        end else if (addr == RAW_ADDR) begin
            rd_hit       = 1'b1;
            rd_data[3:0] = deb_q[0];
            rd_data[7:4] = deb_q[1];
        end
    end

    assign event_pending = event_pending_q;

endmodule

// File: tb/tb_player_input_regs.sv
// Bench for player_input_regs: directed scenarios plus a randomized run
// compared against a behavioural model of the peripheral.
`timescale 1ns/1ps

module tb_player_input_regs;

    localparam int unsigned DC   = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] RAW  = BASE + 32'd4;

    logic        clk;
    logic        reset;
    logic [3:0]  sw_j1, sw_j2;
    logic        time_up;
    logic [31:0] addr;
    logic        re;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        event_pending;

    int n_vec = 0;
    int n_err = 0;

    player_input_regs #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (18),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_j1        (sw_j1),
        .sw_j2        (sw_j2),
        .time_up      (time_up),
        .addr         (addr),
        .re           (re),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .event_pending(event_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: switch samples reach the debouncer two edges late;
    // d takes the sampled value once it has disagreed with d on DC consecutive
    // edges; a fresh one-hot d is latched one edge later if no choice is held.
    logic [3:0] m_s1 [2];
    logic [3:0] m_s2 [2];
    logic [3:0] m_d  [2];
    int         m_run [2];
    logic       m_upd [2];
    logic       m_valid [2];
    logic [1:0] m_choice [2];
    logic       m_tu_prev, m_tu_seen, m_clr;
    logic [3:0] m_sw;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                m_s1[p] = '0; m_s2[p] = '0; m_d[p] = '0; m_run[p] = 0;
                m_upd[p] = 1'b0; m_valid[p] = 1'b0; m_choice[p] = 2'd0;
            end
            m_tu_prev = 1'b0;
            m_tu_seen = 1'b0;
        end else begin
            m_clr = re && (addr == BASE);
            for (int p = 0; p < 2; p++) begin
                m_sw = (p == 0) ? sw_j1 : sw_j2;
                if (m_upd[p] && ($countones(m_d[p]) == 1) && !m_valid[p]) begin
                    m_valid[p] = 1'b1;
                    for (int b = 0; b < 4; b++) if (m_d[p][b]) m_choice[p] = 2'(b);
                end else if (m_clr) begin
                    m_valid[p]  = 1'b0;
                    m_choice[p] = 2'd0;
                end
                m_upd[p] = 1'b0;
                if (m_s2[p] != m_d[p]) begin
                    m_run[p] = m_run[p] + 1;
                    if (m_run[p] == int'(DC)) begin
                        m_d[p]   = m_s2[p];
                        m_run[p] = 0;
                        m_upd[p] = 1'b1;
                    end
                end else begin
                    m_run[p] = 0;
                end
                m_s2[p] = m_s1[p];
                m_s1[p] = m_sw;
            end
            m_tu_seen = (time_up && !m_tu_prev) || (m_tu_seen && !m_clr);
            m_tu_prev = time_up;
        end
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] v;
        v      = '0;
        v[0]   = m_valid[0];
        v[1]   = m_valid[1];
        v[3:2] = m_choice[0];
        v[5:4] = m_choice[1];
        v[8]   = m_tu_seen;
        return v;
    endfunction

    function automatic logic [31:0] exp_raw();
        return {24'd0, m_d[1], m_d[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_at(input logic [31:0] a, output logic [31:0] v, output logic h);
        addr = a;
        #1;
        v = rd_data;
        h = rd_hit;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        h;
        reset = 1'b0; sw_j1 = 4'hF; sw_j2 = 4'hA; time_up = 1'b1; re = 1'b1; addr = BASE;
        tick(); tick();
        re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_status got %h want %h", v, 32'd0); end
        n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL reset_hit_status got %b want 1", h); end
        read_at(RAW, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_raw got %h want %h", v, 32'd0); end
        n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL reset_hit_raw got %b want 1", h); end
        read_at(32'h0000_0200, v, h);
        n_vec++; if ({h, v} !== 33'd0) begin n_err++; $display("FAIL reset_unmapped got hit=%b data=%h want 0/0", h, v); end
        n_vec++; if (event_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", event_pending); end
        time_up = 1'b0; sw_j1 = 4'h0; sw_j2 = 4'h0;
    endtask

    // Release reset with 0100 held; choice index 2 lands in STATUS[3:2].
    task automatic test_latency();
        logic [31:0] v;
        logic        h;
        sw_j1 = 4'b0100; sw_j2 = 4'b0000; re = 1'b0;
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            read_at(BASE, v, h);
            n_vec++;
            if (v !== ((e == 7) ? 32'h9 : 32'h0)) begin
                n_err++; $display("FAIL latency_edge%0d got %h want %h", e, v, (e == 7) ? 32'h9 : 32'h0);
            end
            n_vec++;
            if (event_pending !== (e == 7)) begin
                n_err++; $display("FAIL latency_pending_edge%0d got %b want %b", e, event_pending, (e == 7));
            end
        end
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        logic        h;
        for (int i = 0; i < 10; i++) begin
            sw_j2 = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(); tick();
            read_at(RAW, v, h);
            n_vec++; if (v[7:4] !== 4'd0) begin n_err++; $display("FAIL bounce_raw%0d got %h want 0", i, v[7:4]); end
            read_at(BASE, v, h);
            n_vec++; if (v[1] !== 1'b0) begin n_err++; $display("FAIL bounce_valid%0d got %b want 0", i, v[1]); end
        end
        sw_j2 = 4'b0010;
        repeat (10) tick();
        read_at(BASE, v, h);
        n_vec++; if (v[1] !== 1'b1) begin n_err++; $display("FAIL bounce_settle_valid got %b want 1", v[1]); end
        n_vec++; if (v[5:4] !== 2'd1) begin n_err++; $display("FAIL bounce_settle_choice got %0d want 1", v[5:4]); end
        read_at(RAW, v, h);
        n_vec++; if (v[7:4] !== 4'b0010) begin n_err++; $display("FAIL bounce_settle_raw got %h want 2", v[7:4]); end
    endtask

    task automatic test_first_wins();
        logic [31:0] v;
        logic        h;
        addr = BASE; re = 1'b1; tick(); re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v[1:0] !== 2'b00) begin n_err++; $display("FAIL first_clear got %b want 00", v[1:0]); end
        sw_j1 = 4'b0001;
        repeat (10) tick();
        read_at(BASE, v, h);
        n_vec++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", v[0]); end
        n_vec++; if (v[3:2] !== 2'd0) begin n_err++; $display("FAIL first_choice got %0d want 0", v[3:2]); end
        sw_j1 = 4'b1000;
        repeat (10) tick();
        read_at(BASE, v, h);
        n_vec++; if (v[3:2] !== 2'd0) begin n_err++; $display("FAIL first_kept_choice got %0d want 0", v[3:2]); end
        n_vec++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL first_kept_valid got %b want 1", v[0]); end
        read_at(RAW, v, h);
        n_vec++; if (v[3:0] !== 4'b1000) begin n_err++; $display("FAIL first_raw got %h want 8", v[3:0]); end
    endtask

    task automatic test_multihot();
        logic [31:0] v;
        logic        h;
        addr = BASE; re = 1'b1; tick(); re = 1'b0;
        sw_j1 = 4'b0110; sw_j2 = 4'b0000;
        repeat (10) tick();
        read_at(RAW, v, h);
        n_vec++; if (v !== 32'h6) begin n_err++; $display("FAIL multihot_raw got %h want %h", v, 32'h6); end
        read_at(BASE, v, h);
        n_vec++; if (v[1:0] !== 2'b00) begin n_err++; $display("FAIL multihot_valid got %b want 00", v[1:0]); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        logic        h;
        sw_j1 = 4'b0100;
        repeat (10) tick();
        read_at(BASE, v, h);
        n_vec++; if (v[3:0] !== 4'b1001) begin n_err++; $display("FAIL collide_pre_j1 got %b want 1001", v[3:0]); end
        sw_j2 = 4'b1000;
        repeat (6) tick();
        read_at(BASE, v, h);
        n_vec++; if (v[1] !== 1'b0) begin n_err++; $display("FAIL collide_early_j2 got %b want 0", v[1]); end
        addr = BASE; re = 1'b1;
        tick();
        re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'h32) begin n_err++; $display("FAIL collide_status got %h want %h", v, 32'h32); end
        n_vec++; if (event_pending !== 1'b1) begin n_err++; $display("FAIL collide_pending got %b want 1", event_pending); end
    endtask

    task automatic test_time_up();
        logic [31:0] v;
        logic        h;
        sw_j1 = 4'b0000; sw_j2 = 4'b0000;
        time_up = 1'b1;
        tick();
        read_at(BASE, v, h);
        n_vec++; if (v[8] !== 1'b1) begin n_err++; $display("FAIL tu_first got %b want 1", v[8]); end
        reset = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL tu_rst_status got %h want 0", v); end
        read_at(RAW, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL tu_rst_raw got %h want 0", v); end
        n_vec++; if (event_pending !== 1'b0) begin n_err++; $display("FAIL tu_rst_pending got %b want 0", event_pending); end
        tick();
        time_up = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick();
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL tu_post_rst got %h want 0", v); end
        time_up = 1'b1;
        tick();
        time_up = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'h100) begin n_err++; $display("FAIL tu_edge got %h want %h", v, 32'h100); end
        n_vec++; if (event_pending !== 1'b1) begin n_err++; $display("FAIL tu_pending got %b want 1", event_pending); end
        addr = RAW; re = 1'b1; tick(); re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v[8] !== 1'b1) begin n_err++; $display("FAIL tu_raw_read got %b want 1", v[8]); end
        addr = 32'h0000_0108; re = 1'b1; tick(); re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v[8] !== 1'b1) begin n_err++; $display("FAIL tu_unmapped_read got %b want 1", v[8]); end
        addr = BASE; re = 1'b1; tick(); re = 1'b0;
        read_at(BASE, v, h);
        n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL tu_cleared got %h want 0", v); end
        n_vec++; if (event_pending !== 1'b0) begin n_err++; $display("FAIL tu_cleared_pending got %b want 0", event_pending); end
    endtask

    task automatic test_random();
        logic [31:0] v, other, e;
        logic        h;
        int          hold1, hold2;
        hold1 = 0; hold2 = 0;
        for (int i = 0; i < 2000; i++) begin
            e = exp_status();
            read_at(BASE, v, h);
            n_vec++; if ({h, v} !== {1'b1, e}) begin n_err++; $display("FAIL rand_status cyc%0d got %b/%h want 1/%h", i, h, v, e); end
            e = exp_raw();
            read_at(RAW, v, h);
            n_vec++; if ({h, v} !== {1'b1, e}) begin n_err++; $display("FAIL rand_raw cyc%0d got %b/%h want 1/%h", i, h, v, e); end
            case ($urandom_range(0, 3))
                0:       other = BASE + 32'd8;
                1:       other = BASE - 32'd4;
                2:       other = BASE + 32'd1;
                default: other = $urandom | 32'h8000_0000;
            endcase
            read_at(other, v, h);
            n_vec++; if ({h, v} !== 33'd0) begin n_err++; $display("FAIL rand_unmapped cyc%0d addr %h got %b/%h want 0/0", i, other, h, v); end
            n_vec++;
            if (event_pending !== (m_valid[0] | m_valid[1] | m_tu_seen)) begin
                n_err++; $display("FAIL rand_pending cyc%0d got %b want %b", i, event_pending, (m_valid[0] | m_valid[1] | m_tu_seen));
            end

            if (hold1 == 0) begin
                sw_j1 = ($urandom_range(0, 1) == 1) ? (4'd1 << $urandom_range(0, 3)) : 4'($urandom);
                hold1 = $urandom_range(1, 12);
            end else hold1--;
            if (hold2 == 0) begin
                sw_j2 = ($urandom_range(0, 1) == 1) ? (4'd1 << $urandom_range(0, 3)) : 4'($urandom);
                hold2 = $urandom_range(1, 12);
            end else hold2--;
            case ($urandom_range(0, 2))
                0:       addr = BASE;
                1:       addr = RAW;
                default: addr = other;
            endcase
            re      = ($urandom_range(0, 3) == 0);
            time_up = ($urandom_range(0, 9) == 0) ? ~time_up : time_up;
            reset   = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;
        re    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; sw_j1 = '0; sw_j2 = '0; time_up = 1'b0; addr = '0; re = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_first_wins();
        test_multihot();
        test_collision();
        test_time_up();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
